// File: rtl/t05_translation_seq.sv
// t05_translation_seq: per-character translation sequencer.
// Fetches a character, looks up its Huffman path in the code table, issues it
// to the translation datapath, waits for the datapath, and repeats totChar times.
// Optional watchdog: define T05_TRANSLATION_SEQ_TIMEOUT_EN to bound LOOKUP/WAIT.
//
// Handshakes: a character transfers on a rising edge where char_valid && char_ready;
// code_req/code_addr stay asserted and stable until the edge that samples code_ack;
// trn_start is a one-cycle pulse, and the datapath raises trn_busy the cycle after it.
// All control outputs are registered, decoded from the next state.
module t05_translation_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  totChar,
  input  logic         char_valid,
  input  logic [7:0]   char_in,
  output logic         char_ready,
  output logic         code_req,
  output logic [7:0]   code_addr,
  input  logic         code_ack,
  input  logic [127:0] code_path,
  input  logic [6:0]   code_len,
  output logic [7:0]   trn_charIn,
  output logic [127:0] trn_path,
  output logic [6:0]   trn_len,
  output logic         trn_start,
  input  logic         trn_busy,
  output logic         busy,
  output logic         done,
  output logic [31:0]  char_cnt,
  output logic         err,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOOKUP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [31:0]    tot_reg;
  logic [7:0]     char_reg;
  logic [127:0]   path_reg;
  logic [6:0]     len_reg;
  logic           first_wait;
  logic [31:0]    cnt_inc;
  logic           zero_start;
  logic           timeout;

  assign cnt_inc    = char_cnt + 32'd1;
  assign zero_start = (state == IDLE) && start && (totChar == 32'd0);

  // Translation and lookup operands come straight from the latched registers
  assign code_addr  = char_reg;
  assign trn_charIn = char_reg;
  assign trn_path   = path_reg;
  assign trn_len    = len_reg;
  assign dbg_state  = state;

`ifdef T05_TRANSLATION_SEQ_TIMEOUT_EN
  logic [4:0] wd;

  // Watchdog: counts consecutive LOOKUP/WAIT cycles, cleared whenever the state moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= 5'd0;
    end else if (nxt != state) begin
      wd <= 5'd0;
    end else if (state == LOOKUP || state == WAIT) begin
      wd <= wd + 5'd1;
    end else begin
      wd <= 5'd0;
    end
  end

  // Sixteenth stalled cycle in the same state trips the watchdog
  assign timeout = (wd == 5'd15) && (state == LOOKUP || state == WAIT);
`else
  assign timeout = 1'b0;
`endif

  // Next-state selection; abort overrides every other transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start && totChar != 32'd0) nxt = FETCH;
      FETCH:   if (char_valid) nxt = LOOKUP;
      LOOKUP: begin
        if (code_ack) nxt = (code_len == 7'd0) ? DONE : ISSUE;
        else if (timeout) nxt = ERROR;
      end
      ISSUE:   nxt = WAIT;
      WAIT: begin
        // The first WAIT cycle is skipped: trn_busy only rises one cycle after trn_start
        if (!first_wait && !trn_busy) nxt = (cnt_inc == tot_reg) ? DONE : FETCH;
        else if (timeout) nxt = ERROR;
      end
      DONE:    nxt = IDLE;
      ERROR:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end

  // State register, registered control outputs and job datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      char_ready <= 1'b0;
      code_req   <= 1'b0;
      trn_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      char_cnt   <= 32'd0;
      tot_reg    <= 32'd0;
      char_reg   <= 8'd0;
      path_reg   <= 128'd0;
      len_reg    <= 7'd0;
      first_wait <= 1'b0;
    end else begin
      state      <= nxt;
      char_ready <= (nxt == FETCH);
      code_req   <= (nxt == LOOKUP);
      trn_start  <= (nxt == ISSUE);
      busy       <= (nxt != IDLE);
      first_wait <= (nxt == WAIT) && (state == ISSUE);
      // done: normal completion, empty job, or the cycle after a watchdog error
      done       <= (nxt == DONE) || zero_start || (state == ERROR && !abort);

      if (state == IDLE && start) begin
        tot_reg  <= totChar;
        char_cnt <= 32'd0;
        err      <= 1'b0;
      end
      if (state == FETCH && nxt == LOOKUP) char_reg <= char_in;
      if (state == LOOKUP && nxt == ISSUE) begin
        path_reg <= code_path;
        len_reg  <= code_len;
      end
      // Empty code: flag it and finish the job without translating
      if (state == LOOKUP && nxt == DONE) err <= 1'b1;
      if (state == WAIT && (nxt == DONE || nxt == FETCH)) char_cnt <= cnt_inc;
      if (nxt == ERROR) err <= 1'b1;
    end
  end

endmodule

// File: doc/t05_translation_seq.md
T05_TRANSLATION_SEQ -- requirements
Module: t05_translation_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: start  in  1  job-start pulse; abort  in  1  cancel current job; totChar  in  32  characters in job.
REQ-003 SHALL have char source ports: char_valid  in  1; char_in  in  8  character; char_ready  out  1.
REQ-004 SHALL have code-table ports: code_req  out  1; code_addr  out  8; code_ack  in  1; code_path  in  128  Huffman path bits; code_len  in  7  valid path bits.
REQ-005 SHALL have translation ports: trn_charIn  out  8; trn_path  out  128; trn_len  out  7; trn_start  out  1; trn_busy  in  1.
REQ-006 SHALL have status ports: busy  out  1; done  out  1  one-cycle pulse; char_cnt  out  32  characters completed; err  out  1  sticky error.

Function
REQ-007 SHALL implement states IDLE, FETCH, LOOKUP, ISSUE, WAIT, DONE, and ERROR (ERROR reachable only per REQ-022).
REQ-008 IDLE: on start with totChar!=0 SHALL latch totChar, clear char_cnt and err, and go to FETCH; with totChar==0 SHALL pulse done next cycle and stay IDLE.
REQ-009 start SHALL be ignored in every state except IDLE.
REQ-010 FETCH: char_ready=1; on char_valid&&char_ready SHALL latch char_in and go to LOOKUP; char_ready=0 in all other states.
REQ-011 LOOKUP: code_req=1 and code_addr=latched char, held stable until code_ack; on code_ack SHALL latch code_path and code_len and go to ISSUE.
REQ-012 code_len==0 on ack SHALL set err, skip translation, and go to DONE.
REQ-013 ISSUE: trn_start=1 for exactly one cycle, then WAIT.
REQ-014 trn_charIn, trn_path and trn_len SHALL be driven from latched registers, stable from ISSUE through WAIT exit.
REQ-015 Datapath contract: trn_busy is high the cycle after trn_start. WAIT SHALL exit on the first cycle trn_busy==0, excluding the first WAIT cycle.
REQ-016 On WAIT exit, char_cnt SHALL increment by 1. If the new value equals the latched totChar, go to DONE; else go to FETCH.
REQ-017 DONE: done=1 for one cycle, then IDLE; char_cnt and err SHALL hold until the next accepted start.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 abort in any non-IDLE state SHALL force IDLE next cycle with no done pulse and char_cnt held; abort SHALL take priority over all other transitions.
REQ-020 Latency per character with zero-wait source, ack and datapath SHALL be 5 cycles (FETCH, LOOKUP, ISSUE, 2×WAIT).

Reset
REQ-021 rst high SHALL asynchronously force IDLE and clear all outputs and registers to 0 (char_ready, code_req, trn_start, busy, done, err, char_cnt, code_addr, trn_*), including mid-job.

Configuration
REQ-022 With macro T05_TRANSLATION_SEQ_TIMEOUT_EN defined, a 5-bit watchdog SHALL count consecutive cycles in LOOKUP or WAIT.
  - Reaching 16 SHALL enter ERROR: err=1, then IDLE with a done pulse the following cycle.
  - The watchdog SHALL clear on state change.
  - Without the macro: no watchdog, LOOKUP and WAIT wait indefinitely, and ERROR is unreachable.

Verification
REQ-023 rst pulse mid-WAIT -> all outputs 0 asynchronously, IDLE; subsequent start restarts cleanly.
REQ-024 totChar=2, chars 65 ('A', code_path=0x0A, len 4) then 66 -> two trn_start pulses with trn_charIn=65 then 66, char_cnt=2, one done pulse, err=0.
REQ-025 start with totChar=0 -> done pulse 1 cycle later, char_ready never asserted, char_cnt=0.
REQ-026 totChar=3, abort asserted during second LOOKUP -> IDLE next cycle, no done, char_cnt=1; start during job ignored.
REQ-027 code_len=0 on ack for char 70 -> err=1, no trn_start, done pulse.
REQ-028 Macro defined, code_ack never asserted -> 16 LOOKUP cycles later err=1 and done pulse; macro undefined -> remains LOOKUP indefinitely.
